// File: rtl/led_rotate_pkg.sv
// Shared types and helper functions for the generic digit rotator.
package led_rotate_pkg;

    // Upper bound on NUM_DIGITS*DIGIT_W handled by the helper functions.
    localparam int unsigned DIG_MAX_W = 512;
    localparam int unsigned DIG_IDX_W = $clog2(DIG_MAX_W);

    typedef logic [DIG_MAX_W-1:0] dig_vec_t;

    // Per-cycle action chosen by the step arbiter, highest priority first.
    typedef enum logic [1:0] {
        ACT_HOLD      = 2'd0,
        ACT_LOAD      = 2'd1,
        ACT_STEP_UP   = 2'd2,
        ACT_STEP_DOWN = 2'd3
    } action_e;

    // Rotate up by one digit: d[k] <- d[k-1], d[0] <- d[n-1].
    function automatic dig_vec_t rot_up(input dig_vec_t v, input int unsigned n,
                                        input int unsigned w);
        dig_vec_t    r;
        int unsigned tot;
        r   = '0;
        tot = n * w;
        for (int unsigned i = 0; i < DIG_MAX_W; i++) begin
            if (i < tot) begin
                r[DIG_IDX_W'(i)] = v[DIG_IDX_W'((i + tot - w) % tot)];
            end
        end
        return r;
    endfunction

    // Rotate down by one digit: d[k] <- d[k+1], d[n-1] <- d[0].
    function automatic dig_vec_t rot_down(input dig_vec_t v, input int unsigned n,
                                          input int unsigned w);
        dig_vec_t    r;
        int unsigned tot;
        r   = '0;
        tot = n * w;
        for (int unsigned i = 0; i < DIG_MAX_W; i++) begin
            if (i < tot) begin
                r[DIG_IDX_W'(i)] = v[DIG_IDX_W'((i + w) % tot)];
            end
        end
        return r;
    endfunction

    // Reset pattern: digit k holds k modulo 2^w.
    function automatic dig_vec_t init_digits(input int unsigned n, input int unsigned w);
        dig_vec_t    r;
        logic [31:0] kk;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < n; k++) begin
            kk = 32'(k);
            for (int unsigned b = 0; b < w; b++) begin
                idx = k * w + b;
                if (idx < DIG_MAX_W) begin
                    r[DIG_IDX_W'(idx)] = (b < 32) ? kk[5'(b)] : 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_rotate_n_if.sv
// Control and display bus between the digit source, the rotator and the display mux.
interface led_rotate_n_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_W    = 4
);
    localparam int unsigned TOTAL_W = NUM_DIGITS * DIGIT_W;

    logic               key;
    logic               key_enable;
    logic               up;
    logic               rotate;
    logic               load;
    logic [TOTAL_W-1:0] load_data;
    logic [TOTAL_W-1:0] digits;
    logic               step_pulse;

    modport master (
        output key, key_enable, up, rotate, load, load_data,
        input  digits, step_pulse
    );

    modport slave (
        input  key, key_enable, up, rotate, load, load_data,
        output digits, step_pulse
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for a raw push-button.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous key into the clock domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    // Flip the level after DEBOUNCE_CYCLES consecutive disagreeing samples; flag rising flips.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            key_level <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (sync_q[1] != key_level) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_level <= sync_q[1];
                    key_press <= sync_q[1];
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/led_rotate_n.sv
// N-digit display rotator: auto-rotate tick or debounced key steps the digits one place.
module led_rotate_n
    import led_rotate_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned DIGIT_W         = 4,
    parameter int unsigned TICK_DIV        = 25_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    led_rotate_n_if.slave bus
);

    localparam int unsigned TOTAL_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned TICK_W  = $clog2(TICK_DIV);
    localparam logic [TOTAL_W-1:0] RESET_DIGITS =
        TOTAL_W'(init_digits(NUM_DIGITS, DIGIT_W));

    logic               key_level;
    logic               key_press;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic               tick_c;
    logic               press_c;
    action_e            action_c;
    logic [TOTAL_W-1:0] digits_q;
    logic [TOTAL_W-1:0] digits_next_c;
    logic               pulse_q;
    logic               pulse_next_c;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (bus.key),
        .key_level (key_level),
        .key_press (key_press)
    );

    assign tick_c  = bus.rotate && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    // A press only qualifies while the debounced level is high and presses are enabled.
    assign press_c = key_press && key_level && bus.key_enable;

    // Auto-rotate divider; parked at zero whenever auto-rotate is off.
    always_ff @(posedge clk) begin
        if (!reset || !bus.rotate) begin
            tick_cnt_q <= '0;
        end else if (tick_c) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Arbitrate load over step; coincident tick and press merge into one step.
    always_comb begin
        action_c = ACT_HOLD;
        if (bus.load) begin
            action_c = ACT_LOAD;
        end else if (tick_c || press_c) begin
            action_c = bus.up ? ACT_STEP_UP : ACT_STEP_DOWN;
        end
    end

    // Next digit vector and step strobe for the chosen action.
    always_comb begin
        digits_next_c = digits_q;
        pulse_next_c  = 1'b0;
        case (action_c)
            ACT_LOAD: begin
                digits_next_c = bus.load_data;
            end
            ACT_STEP_UP: begin
                digits_next_c = TOTAL_W'(rot_up(DIG_MAX_W'(digits_q), NUM_DIGITS, DIGIT_W));
                pulse_next_c  = 1'b1;
            end
            ACT_STEP_DOWN: begin
                digits_next_c = TOTAL_W'(rot_down(DIG_MAX_W'(digits_q), NUM_DIGITS, DIGIT_W));
                pulse_next_c  = 1'b1;
            end
            default: begin
                digits_next_c = digits_q;
                pulse_next_c  = 1'b0;
            end
        endcase
    end

    // Digit register and step strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digits_q <= RESET_DIGITS;
            pulse_q  <= 1'b0;
        end else begin
            digits_q <= digits_next_c;
            pulse_q  <= pulse_next_c;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_led_rotate_n.sv
// Directed scoreboard bench for led_rotate_n (N=4, W=4, TICK_DIV=8, DEBOUNCE_CYCLES=4).
module tb_led_rotate_n;

    typedef struct {
        string       tag;
        logic [15:0] d;
        logic        p;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    exp_t sb[$];

    led_rotate_n_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

    led_rotate_n #(
        .NUM_DIGITS      (4),
        .DIGIT_W         (4),
        .TICK_DIV        (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [15:0] d, input logic p);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.p   = p;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        tests++;
        assert (bus.digits === e.d) else begin
            fails++;
            $error("FAIL %s digits: observed %h expected %h", e.tag, bus.digits, e.d);
        end
        tests++;
        assert (bus.step_pulse === e.p) else begin
            fails++;
            $error("FAIL %s step_pulse: observed %b expected %b", e.tag, bus.step_pulse, e.p);
        end
    endtask

    task automatic check_now(input string tag, input logic [15:0] d, input logic p);
        push_exp(tag, d, p);
        pop_check();
    endtask

    task automatic step_expect(input string tag, input logic [15:0] d, input logic p);
        push_exp(tag, d, p);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic hold_expect(input string tag, input int n, input logic [15:0] d);
        for (int i = 0; i < n; i++) begin
            step_expect(tag, d, 1'b0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.key        = 1'b0;
        bus.key_enable = 1'b1;
        bus.up         = 1'b1;
        bus.rotate     = 1'b0;
        bus.load       = 1'b0;
        bus.load_data  = 16'h0000;

        // Reset held for three edges, then released.
        hold_expect("rst_hold", 3, 16'h3210);
        reset = 1'b1;
        check_now("rst_release", 16'h3210, 1'b0);

        // Auto-rotate up: steps at edges 7 and 15, then freeze.
        bus.rotate = 1'b1;
        bus.up     = 1'b1;
        hold_expect("auto_wait1", 7, 16'h3210);
        step_expect("auto_step1", 16'h2103, 1'b1);
        hold_expect("auto_wait2", 7, 16'h2103);
        step_expect("auto_step2", 16'h1032, 1'b1);
        bus.rotate = 1'b0;
        hold_expect("auto_frozen", 20, 16'h1032);

        // Reload base pattern.
        bus.load      = 1'b1;
        bus.load_data = 16'h3210;
        step_expect("load_base", 16'h3210, 1'b0);
        bus.load = 1'b0;

        // Key held 10 cycles, direction down: one step at edge 6.
        bus.up  = 1'b0;
        bus.key = 1'b1;
        hold_expect("key_wait", 6, 16'h3210);
        step_expect("key_step", 16'h0321, 1'b1);
        hold_expect("key_held", 3, 16'h0321);
        bus.key = 1'b0;
        hold_expect("key_release", 14, 16'h0321);

        // Three-cycle glitch: no step.
        bus.key = 1'b1;
        hold_expect("glitch_on", 3, 16'h0321);
        bus.key = 1'b0;
        hold_expect("glitch_off", 12, 16'h0321);

        // Valid press with key_enable low: no step.
        bus.key_enable = 1'b0;
        bus.key        = 1'b1;
        hold_expect("noen_hold", 12, 16'h0321);
        bus.key = 1'b0;
        hold_expect("noen_release", 12, 16'h0321);

        // Press coinciding with a tick: exactly one step up.
        bus.key_enable = 1'b1;
        bus.up         = 1'b1;
        bus.rotate     = 1'b1;
        step_expect("coin_lead", 16'h0321, 1'b0);
        bus.key = 1'b1;
        hold_expect("coin_wait", 6, 16'h0321);
        step_expect("coin_step", 16'h3210, 1'b1);
        bus.rotate = 1'b0;
        step_expect("coin_single", 16'h3210, 1'b0);
        bus.key = 1'b0;
        hold_expect("coin_release", 14, 16'h3210);

        // Load wins over a coincident tick; next tick rotates the loaded value.
        bus.rotate = 1'b1;
        bus.up     = 1'b1;
        hold_expect("ld_wait", 7, 16'h3210);
        bus.load      = 1'b1;
        bus.load_data = 16'hABCD;
        step_expect("ld_win", 16'hABCD, 1'b0);
        bus.load = 1'b0;
        hold_expect("ld_wait2", 7, 16'hABCD);
        step_expect("ld_next", 16'hBCDA, 1'b1);
        step_expect("ld_after", 16'hBCDA, 1'b0);

        // Reset mid-rotation with key held; held key is a fresh press after release.
        bus.key = 1'b1;
        hold_expect("mid_run", 3, 16'hBCDA);
        reset      = 1'b0;
        bus.rotate = 1'b0;
        hold_expect("mid_rst", 2, 16'h3210);
        reset = 1'b1;
        hold_expect("mid_wait", 6, 16'h3210);
        step_expect("mid_step", 16'h2103, 1'b1);
        hold_expect("mid_after", 4, 16'h2103);
        bus.key = 1'b0;
        hold_expect("mid_release", 10, 16'h2103);

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_rotate_n.md
# led_rotate_n

Parametrised N-digit display rotator. It holds `NUM_DIGITS` digit values of `DIGIT_W` bits each and rotates them one position left or right. A rotation happens either on an internal auto-rotate tick or on a debounced key press. The block sits between the digit source (load path) and the display multiplexer/decoder, replacing the fixed 4-digit circulator with a width/depth-generic version that adds debounce, parallel load and a step strobe.

## Interface
- `NUM_DIGITS`, 4, number of digits (≥2)
- `DIGIT_W`, 4, bits per digit (≥1)
- `TICK_DIV`, 25_000_000, clk cycles per auto-rotate step (≥2)
- `DEBOUNCE_CYCLES`, 16, cycles the synchronised key must be stable before the debounced level changes (≥1)

- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low; `reset`=0 at a rising edge resets all state
- `key` in 1: raw asynchronous push-button, active-high
- `key_enable` in 1: 1 lets debounced presses cause a step
- `up` in 1: direction; 1 = rotate up, 0 = rotate down
- `rotate` in 1: 1 enables auto-rotate
- `load` in 1: parallel load strobe
- `load_data` in NUM_DIGITS*DIGIT_W: digit k at bits [k*DIGIT_W +: DIGIT_W]
- `digits` out NUM_DIGITS*DIGIT_W: current digits, same packing, registered
- `step_pulse` out 1: high for one cycle, in the same cycle `digits` shows a rotated value

## Operation
- Reset values:
  - `digits` digit k = k mod 2^DIGIT_W, so the default is d3..d0 = 3,2,1,0.
  - `step_pulse`=0; tick counter=0; synchroniser, debounced level and debounce counter=0.
- Key path:
  - 2-flop synchroniser feeds the debouncer.
  - The debounce counter increments while the synchronised key ≠ the debounced level, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A press is the debounced 0→1 transition; it is a one-cycle pulse.
  - A press is ignored if `key_enable`=0 in that cycle. The debouncer keeps tracking regardless.
- Auto tick:
  - While `rotate`=1, the counter counts 0..TICK_DIV-1. At TICK_DIV-1 it issues a one-cycle tick and wraps to 0.
  - `rotate`=0 holds the counter at 0.
- Step request = tick OR enabled press. Coincident events give a single step, never two.
- Rotation, with d = digit index:
  - up=1: d[k] ← d[k-1] for k≥1, d[0] ← d[N-1].
  - up=0: d[k] ← d[k+1] for k<N-1, d[N-1] ← d[0].
  - `up` is sampled in the step cycle.
- Priority:
  1. reset
  2. load: `digits` ← `load_data`, `step_pulse`=0, and any coincident step is dropped
  3. step
  4. hold
- `load` does not disturb the tick counter or the debouncer.
- Reset mid-operation: all state is cleared regardless of pending ticks or presses. A key held through reset release is seen as a new press after the debounce latency.

## Timing
- Auto: with `rotate` rising before edge 0, the first step is registered at edge TICK_DIV-1 (counter 0 at edge 0). Later steps follow every TICK_DIV edges.
- Key: `key` is first sampled high at edge 0 and held stable.
  - Synchronised key is high after edge 1.
  - The debounced level flips at edge 1+DEBOUNCE_CYCLES.
  - The press pulse is valid in the cycle after that flip.
  - `digits` and `step_pulse` update at edge 2+DEBOUNCE_CYCLES.
- Key pulses shorter than DEBOUNCE_CYCLES produce no step.
- Load: `digits` shows `load_data` after the edge where `load`=1.
- Every step is exactly one position; `step_pulse` is never high in two consecutive cycles from a single event.

## Structure
- Package `led_rotate_pkg`:
  - function `rot_up`/`rot_down` over a packed digit vector, parametrised through the module;
  - reset-pattern function `init_digits(NUM_DIGITS, DIGIT_W)`.
- Sub-module `key_debounce` (parameter DEBOUNCE_CYCLES):
  - ports `clk`, `reset`, `key_raw`, `key_level`, `key_press`;
  - contains the synchroniser and counter.
- Top level contains the tick counter, step arbitration and digit register.

## Test plan
- Reset, defaults (N=4, W=4, DEBOUNCE_CYCLES=4, TICK_DIV=8): hold `reset`=0 for 3 edges, then release → `digits`=0x3210, `step_pulse`=0.
- Auto up: `rotate`=1, up=1 → 0x2103 at edge 7, then 0x1032 at edge 15; `rotate`=0 freezes the value and the counter returns to 0.
- Key down: `rotate`=0, up=0, `key`=1 held for 10 cycles from edge 0 → exactly one step at edge 6, 0x3210→0x0321. A 3-cycle key glitch → no change.
- `key_enable`=0 with a valid press → no step; press with `key_enable`=1 while a tick coincides → a single step only.
- `load`=1 with `load_data`=0xABCD in the same cycle as a tick → `digits`=0xABCD, `step_pulse`=0. The next tick (8 edges later) with up=1 → 0xBCDA.
- Reset asserted mid-rotation with `key` held high → `digits`=0x3210 after reset. After release, one step occurs 6 edges later.
